// File: rtl/braille_word_decoder.sv
// braille_word_decoder
//   Converts a stream of 6-bit Braille digit cells into BCD. Consecutive
//   digits are packed into a right-justified word, and a space cell
//   (6'b000000) closes the word. An invalid cell, or a digit past DIGITS,
//   gives a one-cycle Error pulse. The rest of that word is then discarded
//   up to and including the next space.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   CellIn      6-bit Braille cell
//   CellValid   CellIn is valid this cycle
//   CellReady   the decoder accepts a cell this cycle (registered)
//   BCDOut      packed word; the last digit is in [3:0] and unused nibbles are 0
//   DigitCount  number of digits in BCDOut
//   WordValid   BCDOut/DigitCount are valid; held until WordReady
//   WordReady   the consumer accepts the word
//   Error       one-cycle pulse for an invalid cell or a digit overflow
module braille_word_decoder #(
  parameter int DIGITS = 4,
  parameter int CW     = $clog2(DIGITS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          CellIn,
  input  logic                CellValid,
  output logic                CellReady,
  output logic [4*DIGITS-1:0] BCDOut,
  output logic [CW-1:0]       DigitCount,
  output logic                WordValid,
  input  logic                WordReady,
  output logic                Error
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_COLLECT,
    S_EMIT,
    S_DISCARD
  } state_t;

  state_t         state;
  logic [W-1:0]   acc;
  logic [CW-1:0]  count;
  logic           accept;
  logic           cell_invalid;
  logic           cell_space;
  logic [3:0]     cell_bcd;

  // Result layout: {invalid, space, bcd}.
  function automatic logic [5:0] decode_cell(input logic [5:0] c);
    case (c)
      6'b001110: decode_cell = {2'b00, 4'd0};
      6'b000001: decode_cell = {2'b00, 4'd1};
      6'b000101: decode_cell = {2'b00, 4'd2};
      6'b000011: decode_cell = {2'b00, 4'd3};
      6'b001011: decode_cell = {2'b00, 4'd4};
      6'b001001: decode_cell = {2'b00, 4'd5};
      6'b000111: decode_cell = {2'b00, 4'd6};
      6'b001111: decode_cell = {2'b00, 4'd7};
      6'b001101: decode_cell = {2'b00, 4'd8};
      6'b000110: decode_cell = {2'b00, 4'd9};
      6'b000000: decode_cell = {2'b01, 4'd0};
      default:   decode_cell = {2'b10, 4'd0};
    endcase
  endfunction

  assign {cell_invalid, cell_space, cell_bcd} = decode_cell(CellIn);

  // CellReady is a register, so an accept always matches what the source saw.
  assign accept = CellValid && CellReady;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_COLLECT;
      acc        <= '0;
      count      <= '0;
      BCDOut     <= '0;
      DigitCount <= '0;
      WordValid  <= 1'b0;
      Error      <= 1'b0;
      CellReady  <= 1'b0;
    end else begin
      Error <= 1'b0;
      case (state)
        S_COLLECT: begin
          CellReady <= 1'b1;
          if (accept) begin
            if (cell_invalid) begin
              Error <= 1'b1;
              state <= S_DISCARD;
            end else if (cell_space) begin
              // A space with no digits collected is ignored: no empty words.
              if (count != '0) begin
                BCDOut     <= acc;
                DigitCount <= count;
                WordValid  <= 1'b1;
                CellReady  <= 1'b0;
                state      <= S_EMIT;
              end
            end else if (count == CW'(DIGITS)) begin
              Error <= 1'b1;
              state <= S_DISCARD;
            end else begin
              acc   <= (acc << 4) | W'(cell_bcd);
              count <= count + 1'b1;
            end
          end
        end

        S_EMIT: begin
          // CellReady rises with the handshake edge, so the next cell is
          // accepted no earlier than the edge after the word is taken.
          if (WordReady) begin
            WordValid <= 1'b0;
            CellReady <= 1'b1;
            acc       <= '0;
            count     <= '0;
            state     <= S_COLLECT;
          end
        end

        S_DISCARD: begin
          CellReady <= 1'b1;
          // Digits and invalid cells are swallowed silently until a space.
          if (accept && cell_space) begin
            acc   <= '0;
            count <= '0;
            state <= S_COLLECT;
          end
        end

        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_braille_word_decoder.sv
// Testbench for braille_word_decoder. It holds a queue-based behavioural model
// that is compared with the DUT on every falling edge. Directed vectors carry
// hand-computed literal expectations as well.
module tb_braille_word_decoder;

  localparam int DIGITS = 4;
  localparam int CW     = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [5:0]        CellIn = 6'b0;
  logic              CellValid = 1'b0;
  logic              CellReady;
  logic [4*DIGITS-1:0] BCDOut;
  logic [CW-1:0]     DigitCount;
  logic              WordValid;
  logic              WordReady = 1'b0;
  logic              Error;

  int checks = 0;
  int fails  = 0;

  logic [5:0] codes [10] = '{6'b001110, 6'b000001, 6'b000101, 6'b000011,
                             6'b001011, 6'b001001, 6'b000111, 6'b001111,
                             6'b001101, 6'b000110};
  localparam logic [5:0] SP  = 6'b000000;
  localparam logic [5:0] BAD = 6'b111111;

  braille_word_decoder #(.DIGITS(DIGITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .CellIn     (CellIn),
    .CellValid  (CellValid),
    .CellReady  (CellReady),
    .BCDOut     (BCDOut),
    .DigitCount (DigitCount),
    .WordValid  (WordValid),
    .WordReady  (WordReady),
    .Error      (Error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          q[$];
  bit          m_drop;
  bit          m_wv;
  bit          m_ready;
  bit          m_err;
  logic [15:0] m_bcd;
  int          m_cnt;

  function automatic int digit_of(input logic [5:0] c);
    for (int i = 0; i < 10; i++)
      if (codes[i] == c) return i;
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      begin
        bit took;
        int d;
        if (reset) begin
          q.delete();
          m_drop = 0; m_wv = 0; m_ready = 0; m_err = 0;
          m_bcd = '0; m_cnt = 0;
        end else begin
          took  = CellValid && m_ready;
          m_err = 0;
          if (m_wv) begin
            if (WordReady) begin
              m_wv = 0; m_ready = 1; q.delete();
            end
          end else begin
            m_ready = 1;
            if (took) begin
              d = digit_of(CellIn);
              if (d >= 0) begin
                if (!m_drop) begin
                  if (q.size() == DIGITS) begin
                    m_err = 1; m_drop = 1;
                  end else begin
                    q.push_back(d);
                  end
                end
              end else if (CellIn == SP) begin
                if (m_drop) begin
                  m_drop = 0; q.delete();
                end else if (q.size() > 0) begin
                  m_bcd = '0;
                  foreach (q[i]) m_bcd = 16'(m_bcd * 16 + q[i]);
                  m_cnt = q.size();
                  m_wv = 1; m_ready = 0;
                end
              end else if (!m_drop) begin
                m_err = 1; m_drop = 1;
              end
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_CellReady",  CellReady,  m_ready);
    chk("m_WordValid",  WordValid,  m_wv);
    chk("m_Error",      Error,      m_err);
    chk("m_BCDOut",     BCDOut,     m_bcd);
    chk("m_DigitCount", DigitCount, m_cnt);
  end

  // ---------------- directed stimulus ----------------
  // Called on a falling edge; returns on the falling edge after the accept edge.
  task automatic send(input logic [5:0] c);
    int n;
    CellIn = c;
    CellValid = 1'b1;
    n = 0;
    while (!CellReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; fails++;
      $display("FAIL send_timeout: got CellReady=0 required 1 at %0t", $time);
    end
    @(negedge clk);
    CellValid = 1'b0;
  endtask

  task automatic take_word(input logic [15:0] eb, input int ec);
    int n;
    n = 0;
    while (!WordValid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("word_valid", WordValid, 1);
    chk("word_bcd", BCDOut, eb);
    chk("word_cnt", DigitCount, ec);
    WordReady = 1'b1;
    @(negedge clk);
    WordReady = 1'b0;
    chk("word_valid_drop", WordValid, 0);
    chk("ready_after_word", CellReady, 1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_CellReady"}, CellReady, 0);
    chk({nm, "_WordValid"}, WordValid, 0);
    chk({nm, "_Error"}, Error, 0);
    chk({nm, "_BCDOut"}, BCDOut, 0);
    chk({nm, "_DigitCount"}, DigitCount, 0);
  endtask

  initial begin
    #1;
    chk_zero("reset_init");
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", CellReady, 1);

    // 1: 4,2 -> 0x0042
    send(codes[4]); send(codes[2]); send(SP);
    take_word(16'h0042, 2);

    // 2: every digit alone, then a full four-digit word
    for (int d = 0; d < 10; d++) begin
      send(codes[d]); send(SP);
      take_word(16'(d), 1);
    end
    send(codes[9]); send(codes[8]); send(codes[7]); send(codes[6]); send(SP);
    take_word(16'h9876, 4);

    // 3: overflow on the fifth digit
    for (int d = 1; d <= 5; d++) send(codes[d]);
    chk("overflow_err", Error, 1);
    send(codes[6]);
    chk("discard_no_err", Error, 0);
    send(SP);
    repeat (2) @(negedge clk);
    chk("discard_no_word", WordValid, 0);
    send(codes[3]); send(SP);
    take_word(16'h0003, 1);

    // 4: invalid cell mid-word, then leading spaces
    send(codes[1]); send(BAD);
    chk("invalid_err", Error, 1);
    send(codes[2]);
    chk("invalid_discard_no_err", Error, 0);
    send(SP);
    repeat (2) @(negedge clk);
    chk("invalid_no_word", WordValid, 0);
    send(SP);
    chk("lead_space_no_err", Error, 0);
    send(SP);
    chk("lead_space_no_word", WordValid, 0);
    send(codes[5]); send(SP);
    take_word(16'h0005, 1);

    // 5: back-pressure in EMIT with a pending cell
    send(codes[1]); send(codes[2]); send(SP);
    CellIn = codes[4];
    CellValid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("emit_ready_low", CellReady, 0);
      chk("emit_bcd_stable", BCDOut, 16'h0012);
    end
    WordReady = 1'b1;
    @(negedge clk);
    WordReady = 1'b0;
    chk("emit_release_ready", CellReady, 1);
    @(negedge clk);
    CellValid = 1'b0;
    send(SP);
    take_word(16'h0004, 1);

    // 6: reset mid-word and mid-EMIT
    send(codes[7]); send(codes[8]);
    #2 reset = 1'b1;
    #1 chk_zero("reset_collect");
    @(negedge clk);
    #2 reset = 1'b0;
    send(codes[9]); send(SP);
    chk("pre_reset_emit", WordValid, 1);
    #2 reset = 1'b1;
    #1 chk_zero("reset_emit");
    @(negedge clk);
    #2 reset = 1'b0;
    send(codes[7]); send(SP);
    take_word(16'h0007, 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
